// File: rtl/life_row_engine_if.sv
// Beat and write-back bus between the line buffer / BRAM side and the Life row engine.
interface life_row_engine_if #(
  parameter int ROW_LENGTH = 1280,
  parameter int ADDR_WIDTH = 10
);
  logic [ROW_LENGTH-1:0] top_row;
  logic [ROW_LENGTH-1:0] middle_row;
  logic [ROW_LENGTH-1:0] bottom_row;
  logic [ADDR_WIDTH-1:0] calc_row_in;
  logic                  calc_flg;
  logic                  valid_set;
  logic [8:0]            rule_birth;
  logic [8:0]            rule_survive;
  logic                  wrap_en;
  logic [ROW_LENGTH-1:0] result;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic                  write_en;

  modport master (
    output top_row, middle_row, bottom_row, calc_row_in, calc_flg, valid_set,
           rule_birth, rule_survive, wrap_en,
    input  result, write_addr, write_en
  );

  modport slave (
    input  top_row, middle_row, bottom_row, calc_row_in, calc_flg, valid_set,
           rule_birth, rule_survive, wrap_en,
    output result, write_addr, write_en
  );
endinterface

// File: rtl/life_row_engine.sv
// Two-stage Game-of-Life row engine: one neighbourhood beat in, one next-state row out
// two cycles later, with per-frame live-cell totals and a frame counter.
module life_row_engine #(
  parameter int ROW_LENGTH = 1280,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_ROWS   = 720,
  parameter int POP_WIDTH  = 21
) (
  input  logic                 clk,
  input  logic                 rst,
  life_row_engine_if.slave     row_bus,
  output logic                 frame_done,
  output logic [POP_WIDTH-1:0] live_count,
  output logic [15:0]          generation,
  output logic                 busy
);
  localparam int PC_W = $clog2(ROW_LENGTH + 1);
  localparam logic [ADDR_WIDTH:0]   ROWS_EXT  = (ADDR_WIDTH + 1)'(NUM_ROWS);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_ROWS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_next;

  logic                  beat_ok;
  logic                  s1_vld;
  logic [ROW_LENGTH-1:0] s1_top, s1_mid, s1_bot;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [8:0]            rule_birth_q, rule_survive_q;
  logic                  wrap_q;
  logic [ROW_LENGTH+1:0] t_ext, m_ext, b_ext;
  logic [ROW_LENGTH-1:0] next_row;
  logic [PC_W-1:0]       row_pop;
  logic [POP_WIDTH:0]    acc_sum;
  logic [POP_WIDTH-1:0]  acc, acc_add;

  function automatic logic cell_next(input logic [2:0] t3, input logic [2:0] m3,
                                     input logic [2:0] b3, input logic [8:0] rb,
                                     input logic [8:0] rs);
    logic [3:0] n;
    n = 4'(t3[0]) + 4'(t3[1]) + 4'(t3[2]) + 4'(m3[0]) + 4'(m3[2])
      + 4'(b3[0]) + 4'(b3[1]) + 4'(b3[2]);
    return m3[1] ? rs[n] : rb[n];
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [ROW_LENGTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < ROW_LENGTH; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  assign beat_ok = row_bus.calc_flg & row_bus.valid_set & ({1'b0, row_bus.calc_row_in} < ROWS_EXT);

  // Rule and wrap mode are frame-wide: only a row-0 beat may replace them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld         <= 1'b0;
      s1_top         <= '0;
      s1_mid         <= '0;
      s1_bot         <= '0;
      s1_addr        <= '0;
      rule_birth_q   <= 9'b000001000;
      rule_survive_q <= 9'b000001100;
      wrap_q         <= 1'b0;
    end else begin
      s1_vld <= beat_ok;
      if (beat_ok) begin
        s1_top  <= row_bus.top_row;
        s1_mid  <= row_bus.middle_row;
        s1_bot  <= row_bus.bottom_row;
        s1_addr <= row_bus.calc_row_in;
        if (row_bus.calc_row_in == '0) begin
          rule_birth_q   <= row_bus.rule_birth;
          rule_survive_q <= row_bus.rule_survive;
          wrap_q         <= row_bus.wrap_en;
        end
      end
    end
  end

  // Bit 0 is column -1 and the top bit is column ROW_LENGTH.
  assign t_ext = {wrap_q & s1_top[0], s1_top, wrap_q & s1_top[ROW_LENGTH-1]};
  assign m_ext = {wrap_q & s1_mid[0], s1_mid, wrap_q & s1_mid[ROW_LENGTH-1]};
  assign b_ext = {wrap_q & s1_bot[0], s1_bot, wrap_q & s1_bot[ROW_LENGTH-1]};

  always_comb begin
    next_row = '0;
    for (int i = 0; i < ROW_LENGTH; i++)
      next_row[i] = cell_next(t_ext[i +: 3], m_ext[i +: 3], b_ext[i +: 3],
                              rule_birth_q, rule_survive_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_bus.result     <= '0;
      row_bus.write_addr <= '0;
      row_bus.write_en   <= 1'b0;
    end else begin
      row_bus.write_en <= s1_vld;
      if (s1_vld) begin
        row_bus.result     <= next_row;
        row_bus.write_addr <= s1_addr;
      end
    end
  end

  assign row_pop = popcount(row_bus.result);
  assign acc_sum = {1'b0, acc} + (POP_WIDTH + 1)'(row_pop);
  assign acc_add = acc_sum[POP_WIDTH] ? '1 : acc_sum[POP_WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // s1_vld in IDLE catches a beat that was accepted during DONE.
  always_comb begin
    state_next = state;
    frame_done = 1'b0;
    case (state)
      IDLE: if (beat_ok || s1_vld) state_next = RUN;
      RUN:  if (row_bus.write_en && row_bus.write_addr == LAST_ADDR) state_next = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A row written during DONE already belongs to the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc        <= '0;
      live_count <= '0;
      generation <= '0;
    end else if (state == DONE) begin
      live_count <= acc;
      generation <= generation + 16'd1;
      acc        <= row_bus.write_en ? POP_WIDTH'(row_pop) : '0;
    end else if (row_bus.write_en) begin
      acc <= acc_add;
    end
  end

  assign busy = (state != IDLE) | s1_vld | row_bus.write_en;
endmodule

// File: tb/tb_life_row_engine.sv
// Directed bench for life_row_engine (8-cell rows, 4-row frames) with write and frame scoreboards.
module tb_life_row_engine;
  localparam int RL = 8;
  localparam int AW = 4;
  localparam int NR = 4;
  localparam int PW = 8;
  localparam logic [8:0] B3  = 9'b000001000;
  localparam logic [8:0] S23 = 9'b000001100;
  localparam logic [8:0] B36 = 9'b001001000;

  typedef struct {
    logic [AW-1:0] addr;
    logic [RL-1:0] row;
    int            cyc;
  } wr_t;

  typedef struct {
    logic [PW-1:0] live;
    logic [15:0]   gen;
  } fr_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_done;
  logic [PW-1:0] live_count;
  logic [15:0]   generation;
  logic          busy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [RL-1:0] wr_row;

  wr_t  wq[$];
  fr_t  fq[$];
  fr_t  pend_fr;
  bit   pend = 0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   frame_pop = 0;
  logic [15:0] gen_exp = 16'd0;
  logic [8:0]  lat_rb = B3;
  logic [8:0]  lat_rs = S23;
  logic        lat_w = 1'b0;

  life_row_engine_if #(.ROW_LENGTH(RL), .ADDR_WIDTH(AW)) bus_if ();

  life_row_engine #(
    .ROW_LENGTH(RL), .ADDR_WIDTH(AW), .NUM_ROWS(NR), .POP_WIDTH(PW)
  ) dut (
    .clk(clk), .rst(rst), .row_bus(bus_if), .frame_done(frame_done),
    .live_count(live_count), .generation(generation), .busy(busy)
  );

  assign wr_en   = bus_if.write_en;
  assign wr_addr = bus_if.write_addr;
  assign wr_row  = bus_if.result;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Independent reference: explicit neighbour walk with modular column indexing.
  function automatic logic [RL-1:0] model(input logic [RL-1:0] t, input logic [RL-1:0] m,
                                          input logic [RL-1:0] b, input logic [8:0] rb,
                                          input logic [8:0] rs, input logic w);
    logic [RL-1:0] r;
    r = '0;
    for (int c = 0; c < RL; c++) begin
      int n;
      n = 0;
      for (int d = -1; d <= 1; d++) begin
        int col;
        col = c + d;
        if (col < 0 || col >= RL) begin
          if (!w) continue;
          col = (col + RL) % RL;
        end
        n += int'(t[col]) + int'(b[col]);
        if (d != 0) n += int'(m[col]);
      end
      r[c] = m[c] ? rs[n] : rb[n];
    end
    return r;
  endfunction

  task automatic beat(input logic [AW-1:0] row, input logic [RL-1:0] t, input logic [RL-1:0] m,
                      input logic [RL-1:0] b, input logic [8:0] rb, input logic [8:0] rs,
                      input logic w, input logic [RL-1:0] exp, input bit expect_wr);
    wr_t e;
    fr_t f;
    @(posedge clk);
    #1;
    bus_if.calc_row_in  = row;
    bus_if.top_row      = t;
    bus_if.middle_row   = m;
    bus_if.bottom_row   = b;
    bus_if.rule_birth   = rb;
    bus_if.rule_survive = rs;
    bus_if.wrap_en      = w;
    bus_if.calc_flg     = 1'b1;
    bus_if.valid_set    = 1'b1;
    if (expect_wr) begin
      if (row == 0) begin
        lat_rb = rb;
        lat_rs = rs;
        lat_w  = w;
      end
      e.addr = row;
      e.row  = exp;
      e.cyc  = cyc + 2;
      wq.push_back(e);
      frame_pop += $countones(exp);
      if (row == AW'(NR - 1)) begin
        gen_exp = gen_exp + 16'd1;
        f.live  = PW'(frame_pop);
        f.gen   = gen_exp;
        fq.push_back(f);
        frame_pop = 0;
      end
    end
  endtask

  task automatic rbeat(input logic [AW-1:0] row, input logic [8:0] rb, input logic [8:0] rs,
                       input logic w);
    logic [RL-1:0] t, m, b;
    t = RL'($urandom);
    m = RL'($urandom);
    b = RL'($urandom);
    beat(row, t, m, b, rb, rs, w,
         model(t, m, b, (row == 0) ? rb : lat_rb, (row == 0) ? rs : lat_rs,
               (row == 0) ? w : lat_w), 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus_if.calc_flg  = 1'b0;
      bus_if.valid_set = 1'b0;
    end
  endtask

  task automatic drain(input int max);
    bit ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (wq.size() == 0 && fq.size() == 0 && !pend && !busy) begin
        ok = 1;
        break;
      end
    end
    chk("drain_complete", 32'(ok), 32'd1);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        chk("frame_done_width", 32'(frame_done), 32'd0);
        chk("live_count", 32'(live_count), 32'(pend_fr.live));
        chk("generation", 32'(generation), 32'(pend_fr.gen));
        pend = 0;
      end
      if (frame_done) begin
        chk("frame_done_expected", 32'(fq.size() != 0), 32'd1);
        if (fq.size() != 0) begin
          pend_fr = fq.pop_front();
          pend    = 1;
        end
      end
      if (wr_en) begin
        chk("write_expected", 32'(wq.size() != 0), 32'd1);
        if (wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("write_addr", 32'(wr_addr), 32'(e.addr));
          chk("write_result", 32'(wr_row), 32'(e.row));
          chk("write_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus_if.calc_flg = 1'b0;  bus_if.valid_set = 1'b0;  bus_if.calc_row_in = '0;
    bus_if.top_row = '0;     bus_if.middle_row = '0;   bus_if.bottom_row = '0;
    bus_if.rule_birth = B3;  bus_if.rule_survive = S23; bus_if.wrap_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_write_en", 32'(wr_en), 32'd0);
    chk("rst_result", 32'(wr_row), 32'd0);
    chk("rst_write_addr", 32'(wr_addr), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_live_count", 32'(live_count), 32'd0);
    chk("rst_generation", 32'(generation), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Frame 1: blinker, vertical blinker, empty, block -> 1,3,0,2 live.
    beat(0, 8'h00, 8'b00011100, 8'h00, B3, S23, 1'b0, 8'b00001000, 1'b1);
    beat(1, 8'b10, 8'b10, 8'b10, B3, S23, 1'b0, 8'b00000111, 1'b1);
    beat(2, 8'h00, 8'h00, 8'h00, B3, S23, 1'b0, 8'h00, 1'b1);
    beat(3, 8'b11, 8'b11, 8'h00, B3, S23, 1'b0, 8'b00000011, 1'b1);
    @(negedge clk);
    chk("busy_running", 32'(busy), 32'd1);
    idle(1);
    drain(30);

    // Out-of-range row and missing valid_set must both be ignored.
    beat(5, 8'hFF, 8'hFF, 8'hFF, B3, S23, 1'b0, 8'h00, 1'b0);
    idle(1);
    @(negedge clk);
    chk("oor_busy", 32'(busy), 32'd0);
    idle(1);
    @(negedge clk);
    chk("oor_no_write", 32'(wr_en), 32'd0);
    @(posedge clk);
    #1;
    bus_if.calc_row_in = '0;
    bus_if.calc_flg    = 1'b1;
    bus_if.valid_set   = 1'b0;
    idle(1);
    @(negedge clk);
    chk("novalid_busy", 32'(busy), 32'd0);
    idle(1);
    @(negedge clk);
    chk("novalid_no_write", 32'(wr_en), 32'd0);

    // Frame 2: toroidal edges.
    beat(0, 8'h01, 8'h01, 8'h01, B3, S23, 1'b1, 8'b10000011, 1'b1);
    for (int r = 1; r < NR; r++) beat(AW'(r), 8'h00, 8'h00, 8'h00, B3, S23, 1'b0, 8'h00, 1'b1);
    idle(1);
    drain(30);

    // Frame 3: dead edges; wrap and rule inputs on later rows must be ignored.
    beat(0, 8'h01, 8'h01, 8'h01, B3, S23, 1'b0, 8'b00000011, 1'b1);
    beat(1, 8'h01, 8'h01, 8'h01, B3, S23, 1'b1, 8'b00000011, 1'b1);
    beat(2, 8'b111, 8'b101, 8'b001, B36, S23, 1'b0, 8'b00000101, 1'b1);
    beat(3, 8'b111, 8'b101, 8'b001, B36, S23, 1'b0, 8'b00000101, 1'b1);
    idle(1);
    drain(30);

    // Frames 4 and 5 back to back, so frame 5 starts while frame 4 is in DONE.
    beat(0, 8'b111, 8'b101, 8'b001, B36, S23, 1'b0, 8'b00000111, 1'b1);
    for (int r = 1; r < NR; r++) rbeat(AW'(r), B3, S23, 1'b1);
    rbeat(0, B3, S23, 1'b1);
    for (int r = 1; r < NR; r++) rbeat(AW'(r), B36, 9'h1FF, 1'b0);
    idle(1);
    drain(40);

    // Reset mid-frame aborts rows 0..1 and restores the default rule.
    beat(0, 8'h00, 8'b00011100, 8'h00, B3, S23, 1'b0, 8'h00, 1'b0);
    beat(1, 8'h00, 8'b00011100, 8'h00, B3, S23, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus_if.calc_flg  = 1'b0;
    bus_if.valid_set = 1'b0;
    frame_pop = 0;
    gen_exp   = 16'd0;
    lat_rb = B3;
    lat_rs = S23;
    lat_w  = 1'b0;
    @(negedge clk);
    chk("midrst_write_en", 32'(wr_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_write_en", 32'(wr_en), 32'd0);
    chk("postrst_frame_done", 32'(frame_done), 32'd0);
    chk("postrst_live_count", 32'(live_count), 32'd0);
    chk("postrst_generation", 32'(generation), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);

    // Rows 1..3 without a row-0 beat run on the reset rule B3/S23 with dead edges.
    for (int r = 1; r < NR; r++)
      beat(AW'(r), 8'b111, 8'b101, 8'b001, B36, S23, 1'b1, 8'b00000101, 1'b1);
    idle(1);
    drain(30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
